dmem_arbiter: RTL and testbench

//  Two-port arbiter sharing the single-ported data memory (async read, sync write, word-addressed by addr[9:2]).

---
 rtl/rv_mem_pkg.sv | 29 ++
 rtl/dmem_rr_grant2.sv | 33 +++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   DMEM_DEPTH / DMEM_AW : default memory depth (words) and word-index width
//   arb_state_e          : arbiter FSM states
//   port_sel_e           : port-select encoding for the mux and RR pointer
//   dmem_req_t           : request fields bundled for the port mux
package rv_mem_pkg;

  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_AW    = 8;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } port_sel_e;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_rr_grant2.sv
// Two-requester grant with a round-robin pointer.
//   clk, rst     : clock, synchronous active-high reset (pointer -> SEL_A)
//   req_a, req_b : requests (already masked by the caller for lock/reset)
//   gnt_a, gnt_b : one-hot-or-zero grants, combinational from the requests
// FIXED_PRIO=1 makes A win every conflict; otherwise the pointer port wins and
// the pointer moves to the port that did not just win.
module dmem_rr_grant2
  import rv_mem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  port_sel_e ptr_q;

  always_comb begin
    gnt_a = req_a & (~req_b | FIXED_PRIO | (ptr_q == SEL_A));
    gnt_b = req_b & ~gnt_a;
  end

  always_ff @(posedge clk) begin
    if (rst)        ptr_q <= SEL_A;
    else if (gnt_a) ptr_q <= SEL_B;
    else if (gnt_b) ptr_q <= SEL_A;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (async read,
// sync write). Port A = CPU MEM stage, port B = loader/debug DMA.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_x_valid / o_x_ready        : request handshake (ready = accepted now)
//   i_x_we, i_x_lock             : write enable, keep grant after this request
//   i_x_addr, i_x_wdata          : byte address, write data
//   o_x_rsp_valid/err/rdata      : registered response, one cycle after accept
//   o_mem_we/addr/wdata          : memory drive, muxed from the granted port
//   i_mem_rdata                  : combinational memory read data
module dmem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int AW         = DMEM_AW,
  parameter int FIXED_PRIO = 0,
  parameter int LOCK_MAX   = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  output logic        o_a_ready,
  input  logic        i_a_we,
  input  logic        i_a_lock,
  input  logic [31:0] i_a_addr,
  input  logic [31:0] i_a_wdata,
  output logic        o_a_rsp_valid,
  output logic        o_a_rsp_err,
  output logic [31:0] o_a_rsp_rdata,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic        i_b_we,
  input  logic        i_b_lock,
  input  logic [31:0] i_b_addr,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_rsp_valid,
  output logic        o_b_rsp_err,
  output logic [31:0] o_b_rsp_rdata,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW    = $clog2(LOCK_MAX + 1);
  localparam int WORDS = 1 << AW;

  // Word-aligned and the word index is inside both the memory depth and the
  // AW-bit index space.
  function automatic logic addr_legal(input logic [31:0] addr);
    logic [31:0] widx;
    widx = {2'b00, addr[31:2]};
    return (addr[1:0] == 2'b00) && (widx < 32'(DEPTH)) && (widx < 32'(WORDS));
  endfunction

  arb_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  dmem_req_t      a_req, b_req, sel_req;
  logic           req_a, req_b, gnt_a, gnt_b, acc;
  logic           a_legal, b_legal;

  assign a_req = '{we: i_a_we, lock: i_a_lock, addr: i_a_addr, wdata: i_a_wdata};
  assign b_req = '{we: i_b_we, lock: i_b_lock, addr: i_b_addr, wdata: i_b_wdata};

  // The lock owner is the only port that may request; nobody is granted
  // while reset is held.
  assign req_a = i_a_valid & ~i_rst & (state_q != ST_LOCK_B);
  assign req_b = i_b_valid & ~i_rst & (state_q != ST_LOCK_A);

  dmem_rr_grant2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_grant (
    .clk   (i_clk),
    .rst   (i_rst),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign acc       = gnt_a | gnt_b;
  assign sel_req   = gnt_b ? b_req : a_req;
  assign a_legal   = addr_legal(i_a_addr);
  assign b_legal   = addr_legal(i_b_addr);

  assign o_a_ready   = gnt_a;
  assign o_b_ready   = gnt_b;
  assign o_mem_addr  = sel_req.addr;
  assign o_mem_wdata = sel_req.wdata;
  assign o_mem_we    = acc & sel_req.we & (gnt_b ? b_legal : a_legal);

  // Lock FSM. While locked, the counter tracks consecutive idle cycles of the
  // owner; the release edge is the one on which it would reach LOCK_MAX, so
  // exactly LOCK_MAX idle cycles are tolerated.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ARB: begin
        if (acc && sel_req.lock) state_d = gnt_a ? ST_LOCK_A : ST_LOCK_B;
      end
      ST_LOCK_A, ST_LOCK_B: begin
        if (acc) begin
          cnt_d = '0;
          if (!sel_req.lock) state_d = ST_ARB;
        end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
          cnt_d   = '0;
          state_d = ST_ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Responses: read data is sampled from memory at the accept edge; writes and
  // illegal requests return zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_a_rsp_valid <= 1'b0;
      o_a_rsp_err   <= 1'b0;
      o_a_rsp_rdata <= '0;
      o_b_rsp_valid <= 1'b0;
      o_b_rsp_err   <= 1'b0;
      o_b_rsp_rdata <= '0;
    end else begin
      o_a_rsp_valid <= gnt_a;
      o_a_rsp_err   <= gnt_a & ~a_legal;
      o_a_rsp_rdata <= (gnt_a && a_legal && !i_a_we) ? i_mem_rdata : '0;
      o_b_rsp_valid <= gnt_b;
      o_b_rsp_err   <= gnt_b & ~b_legal;
      o_b_rsp_rdata <= (gnt_b && b_legal && !i_b_we) ? i_mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid, a_we, a_lock, b_valid, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ready, a_rsp_valid, a_rsp_err, b_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fp_a_ready, fp_a_rsp_valid, fp_a_rsp_err, fp_b_ready, fp_b_rsp_valid, fp_b_rsp_err;
  logic [31:0] fp_a_rsp_rdata, fp_b_rsp_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_we;

  logic [31:0] mem  [0:255];
  logic [31:0] mmem [0:255];

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] = mem_wdata;

  dmem_arbiter #(.FIXED_PRIO(0), .LOCK_MAX(LOCK_MAX)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_we(a_we), .i_a_lock(a_lock),
    .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_rsp_valid(a_rsp_valid), .o_a_rsp_err(a_rsp_err), .o_a_rsp_rdata(a_rsp_rdata),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_we(b_we), .i_b_lock(b_lock),
    .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_rsp_valid(b_rsp_valid), .o_b_rsp_err(b_rsp_err), .o_b_rsp_rdata(b_rsp_rdata),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.FIXED_PRIO(1), .LOCK_MAX(LOCK_MAX)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .o_a_ready(fp_a_ready), .i_a_we(a_we), .i_a_lock(a_lock),
    .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_rsp_valid(fp_a_rsp_valid), .o_a_rsp_err(fp_a_rsp_err), .o_a_rsp_rdata(fp_a_rsp_rdata),
    .i_b_valid(b_valid), .o_b_ready(fp_b_ready), .i_b_we(b_we), .i_b_lock(b_lock),
    .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_rsp_valid(fp_b_rsp_valid), .o_b_rsp_err(fp_b_rsp_err), .o_b_rsp_rdata(fp_b_rsp_rdata),
    .o_mem_we(fp_mem_we), .o_mem_addr(fp_mem_addr), .o_mem_wdata(fp_mem_wdata), .i_mem_rdata(32'h0)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Legal = word aligned and below DEPTH*4 bytes.
  function automatic bit legal(input logic [31:0] ad);
    return (ad[1:0] == 2'b00) && (ad < 32'h400);
  endfunction

  // Model: owner of the lock (-1 none, 0 A, 1 B), owner idle cycles, RR pointer,
  // expected responses for the next cycle, and a shadow memory.
  int          own = -1, idle = 0, ptr = 0;
  logic        e_av = 0, e_aerr = 0, e_bv = 0, e_berr = 0;
  logic [31:0] e_ard = 0, e_brd = 0;

  always @(negedge clk) begin
    logic        ea, eb, s_we, s_lk, s_lg;
    logic [31:0] s_ad, s_wd;
    int          acc;
    ea = 0; eb = 0;
    if (!rst) begin
      if (own == 0)                ea = a_valid;
      else if (own == 1)           eb = b_valid;
      else if (a_valid && b_valid) begin ea = (ptr == 0); eb = (ptr == 1); end
      else begin ea = a_valid; eb = b_valid; end
    end
    acc  = ea ? 0 : (eb ? 1 : -1);
    s_we = eb ? b_we   : a_we;
    s_lk = eb ? b_lock : a_lock;
    s_ad = eb ? b_addr : a_addr;
    s_wd = eb ? b_wdata : a_wdata;
    s_lg = legal(s_ad);

    chk("a_rsp_valid", a_rsp_valid, e_av);
    if (e_av) begin chk("a_rsp_err", a_rsp_err, e_aerr); chk("a_rsp_rdata", a_rsp_rdata, e_ard); end
    chk("b_rsp_valid", b_rsp_valid, e_bv);
    if (e_bv) begin chk("b_rsp_err", b_rsp_err, e_berr); chk("b_rsp_rdata", b_rsp_rdata, e_brd); end
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("mem_we", mem_we, (acc >= 0) && s_we && s_lg);
    chk("mem_addr", mem_addr, s_ad);
    chk("mem_wdata", mem_wdata, s_wd);

    if (rst) begin
      own = -1; idle = 0; ptr = 0; e_av = 0; e_bv = 0;
    end else begin
      e_av = ea; e_bv = eb;
      if (acc >= 0) begin
        if (acc == 0) begin e_aerr = !s_lg; e_ard = (s_lg && !s_we) ? mmem[s_ad[9:2]] : 0; end
        else          begin e_berr = !s_lg; e_brd = (s_lg && !s_we) ? mmem[s_ad[9:2]] : 0; end
        if (s_we && s_lg) mmem[s_ad[9:2]] = s_wd;
        ptr = 1 - acc;
        if (own < 0) begin
          if (s_lk) begin own = acc; idle = 0; end
        end else begin
          idle = 0;
          if (!s_lk) own = -1;
        end
      end else if (own >= 0) begin
        idle++;
        if (idle == LOCK_MAX) begin own = -1; idle = 0; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_in();
    a_valid = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_in();
    step(); step();
    rst = 0;
  endtask

  logic [3:0] rr_pat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'hA500_0000 | i;
      mmem[i] = 32'hA500_0000 | i;
    end
    mem[4] = 32'hDEAD_BEEF; mmem[4] = 32'hDEAD_BEEF;
    rr_pat = 4'b0101;

    // Reset state: a request during reset is not accepted.
    rst = 1; idle_in(); a_valid = 1; a_addr = 32'h10;
    mid();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_a_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);
    step(); rst = 0; idle_in();

    // 1: single read of word 4.
    a_valid = 1; a_addr = 32'h10;
    mid(); chk("t1_a_ready", a_ready, 1);
    step(); idle_in();
    mid();
    chk("t1_rsp_valid", a_rsp_valid, 1);
    chk("t1_rsp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
    chk("t1_rsp_err", a_rsp_err, 0);

    // 2: both valid after reset: RR gives A,B,A,B; fixed priority gives A x4.
    do_reset();
    a_valid = 1; b_valid = 1; a_addr = 32'h0; b_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t2_rr_a_ready", a_ready, rr_pat[k]);
      chk("t2_rr_b_ready", b_ready, !rr_pat[k]);
      chk("t2_fp_a_ready", fp_a_ready, 1);
      step();
    end
    idle_in();

    // 3: B writes, A reads the same word the next cycle.
    b_valid = 1; b_we = 1; b_addr = 32'h20; b_wdata = 32'h55AA;
    mid(); chk("t3_b_ready", b_ready, 1);
    step(); idle_in(); a_valid = 1; a_addr = 32'h20;
    mid(); chk("t3_a_ready", a_ready, 1);
    step(); idle_in();
    mid();
    chk("t3_a_rsp_valid", a_rsp_valid, 1);
    chk("t3_a_rsp_rdata", a_rsp_rdata, 32'h0000_55AA);

    // 4: A locks then idles; B waits out LOCK_MAX idle cycles.
    a_valid = 1; a_lock = 1; a_addr = 32'h10;
    mid(); chk("t4_a_ready", a_ready, 1);
    step(); idle_in(); b_valid = 1; b_addr = 32'h24;
    for (int k = 1; k <= 16; k++) begin
      mid(); chk("t4_b_ready", b_ready, k == 16);
      step();
    end
    idle_in();

    // 5: misaligned read and out-of-range write.
    a_valid = 1; a_addr = 32'h402;
    mid(); chk("t5_rd_ready", a_ready, 1); chk("t5_rd_mem_we", mem_we, 0);
    step(); a_we = 1; a_addr = 32'h400; a_wdata = 32'h1234_5678;
    mid();
    chk("t5_rd_err", a_rsp_err, 1);
    chk("t5_rd_rdata", a_rsp_rdata, 0);
    chk("t5_wr_mem_we", mem_we, 0);
    step(); idle_in();
    mid();
    chk("t5_wr_rsp_valid", a_rsp_valid, 1);
    chk("t5_wr_err", a_rsp_err, 1);
    chk("t5_wr_rdata", a_rsp_rdata, 0);
    chk("t5_mem0", mem[0], 32'hA500_0000);

    // 6: reset while LOCK_B with a response pending.
    step();
    b_valid = 1; b_lock = 1; b_addr = 32'h8;
    mid(); chk("t6_b_ready0", b_ready, 1);
    step();
    mid(); chk("t6_b_ready1", b_ready, 1);
    step(); rst = 1; idle_in();
    mid(); chk("t6_rst_b_rsp", b_rsp_valid, 1); chk("t6_rst_b_ready", b_ready, 0);
    step(); rst = 0;
    a_valid = 1; b_valid = 1; a_addr = 32'h0; b_addr = 32'h4;
    mid();
    chk("t6_a_ready", a_ready, 1);
    chk("t6_b_ready", b_ready, 0);
    chk("t6_a_rsp_valid", a_rsp_valid, 0);
    chk("t6_b_rsp_valid", b_rsp_valid, 0);
    step(); idle_in();
    mid(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
